// File: rtl/brnch_pc_redirect_ctrl.sv
// Purpose : IF-stage next-PC / redirect controller: PC register, direct-mapped BTB,
//           IF/ID prediction record, mispredict flush and saturating perf counters.
// Latency : mispredict seen in cycle N -> corrected pc_if in N+1 (one fetch bubble);
//           flush_if_id is combinational in cycle N.
// Backpress: stall_if holds PC and IF/ID record; a redirect overrides stall_if.
//           brch_hazard_stall defers resolution (no flush, BTB write or count).
//
// Ports:
//   clk, rst                 clock, async active-high reset
//   stall_if                 hold PC and IF/ID record
//   brch_instr_detectd_IF    predecode: instruction at pc_if is a branch
//   predict_br_taken         direction predictor output for the IF branch
//   brch_instr_detectd_ID    branch present in ID
//   brch_hazard_stall        branch operands not ready, defer resolution
//   actual_brch_result       resolved direction (1 = taken)
//   brch_target_ID           resolved taken target
//   pc_if / pc_id            fetch address / PC of the ID instruction
//   pred_taken_id            effective prediction carried with the ID instruction
//   flush_if_id              kill the IF/ID instruction this cycle
//   brch_resolved_cnt        resolved branches (saturating)
//   brch_mispred_cnt         mispredicted branches (saturating)
module brnch_pc_redirect_ctrl #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          BTB_IDX_W = 4,
  parameter int          CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall_if,
  input  logic             brch_instr_detectd_IF,
  input  logic             predict_br_taken,
  input  logic             brch_instr_detectd_ID,
  input  logic             brch_hazard_stall,
  input  logic             actual_brch_result,
  input  logic [31:0]      brch_target_ID,
  output logic [31:0]      pc_if,
  output logic [31:0]      pc_id,
  output logic             pred_taken_id,
  output logic             flush_if_id,
  output logic [CNT_W-1:0] brch_resolved_cnt,
  output logic [CNT_W-1:0] brch_mispred_cnt
);

  localparam int ENTRIES = 1 << BTB_IDX_W;
  localparam int TAG_W   = 32 - BTB_IDX_W - 2;

  logic [ENTRIES-1:0] btb_vld;
  logic [TAG_W-1:0]   btb_tag [ENTRIES];
  logic [31:0]        btb_tgt [ENTRIES];

  logic [BTB_IDX_W-1:0] if_idx;
  logic [BTB_IDX_W-1:0] id_idx;
  logic [TAG_W-1:0]     if_tag;
  logic [TAG_W-1:0]     id_tag;
  logic                 btb_hit;
  logic                 eff_pred;
  logic                 resolve;
  logic                 mispred;
  logic                 btb_wr;
  logic [31:0]          next_pc;

  assign if_idx = pc_if[BTB_IDX_W+1:2];
  assign id_idx = pc_id[BTB_IDX_W+1:2];
  assign if_tag = pc_if[31:BTB_IDX_W+2];
  assign id_tag = pc_id[31:BTB_IDX_W+2];

  // Registered array read: a same-index write this cycle is not yet visible.
  assign btb_hit  = btb_vld[if_idx] && (btb_tag[if_idx] == if_tag);
  // A taken prediction without a BTB target cannot be steered, so it falls through.
  assign eff_pred = brch_instr_detectd_IF && predict_br_taken && btb_hit;

  // Gated by rst so a redirect in flight while reset is asserted is dropped.
  assign resolve     = brch_instr_detectd_ID && !brch_hazard_stall && !rst;
  assign mispred     = resolve && (actual_brch_result != pred_taken_id);
  assign flush_if_id = mispred;
  assign btb_wr      = resolve && actual_brch_result;

  always_comb begin
    next_pc = pc_if + 32'd4;
    if (mispred && actual_brch_result) begin
      next_pc = brch_target_ID;
    end else if (mispred) begin
      next_pc = pc_id + 32'd4;
    end else if (stall_if) begin
      next_pc = pc_if;
    end else if (eff_pred) begin
      next_pc = btb_tgt[if_idx];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_if         <= RESET_PC;
      pc_id         <= 32'd0;
      pred_taken_id <= 1'b0;
    end else begin
      pc_if <= next_pc;
      if (mispred) begin
        pc_id         <= 32'd0;
        pred_taken_id <= 1'b0;
      end else if (!stall_if) begin
        pc_id         <= pc_if;
        pred_taken_id <= eff_pred;
      end
    end
  end

  // Only the valid bits need reset; tag/target are qualified by valid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      btb_vld <= '0;
    end else if (btb_wr) begin
      btb_vld[id_idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (btb_wr) begin
      btb_tag[id_idx] <= id_tag;
      btb_tgt[id_idx] <= brch_target_ID;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      brch_resolved_cnt <= '0;
      brch_mispred_cnt  <= '0;
    end else begin
      if (resolve && !(&brch_resolved_cnt)) brch_resolved_cnt <= brch_resolved_cnt + 1'b1;
      if (mispred && !(&brch_mispred_cnt))  brch_mispred_cnt  <= brch_mispred_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_brnch_pc_redirect_ctrl.sv
module tb_brnch_pc_redirect_ctrl;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        stall_if = 1'b0;
  logic        brch_instr_detectd_IF = 1'b0;
  logic        predict_br_taken = 1'b0;
  logic        brch_instr_detectd_ID = 1'b0;
  logic        brch_hazard_stall = 1'b0;
  logic        actual_brch_result = 1'b0;
  logic [31:0] brch_target_ID = 32'd0;
  logic [31:0] pc_if;
  logic [31:0] pc_id;
  logic        pred_taken_id;
  logic        flush_if_id;
  logic [15:0] brch_resolved_cnt;
  logic [15:0] brch_mispred_cnt;

  int n_err = 0;
  int n_checks = 0;

  // Scoreboard: expected next pc_if pushed when stimulus is driven, popped after the edge.
  logic [31:0] exp_pc_q[$];
  string       exp_nm_q[$];
  logic [31:0] e_pc;
  string       e_nm;

  brnch_pc_redirect_ctrl #(.RESET_PC(RESET_PC), .BTB_IDX_W(4), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .stall_if(stall_if),
    .brch_instr_detectd_IF(brch_instr_detectd_IF), .predict_br_taken(predict_br_taken),
    .brch_instr_detectd_ID(brch_instr_detectd_ID), .brch_hazard_stall(brch_hazard_stall),
    .actual_brch_result(actual_brch_result), .brch_target_ID(brch_target_ID),
    .pc_if(pc_if), .pc_id(pc_id), .pred_taken_id(pred_taken_id), .flush_if_id(flush_if_id),
    .brch_resolved_cnt(brch_resolved_cnt), .brch_mispred_cnt(brch_mispred_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #1_500_000;
    $display("FAIL watchdog: time limit reached, errors=%0d", n_err);
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    stall_if = 0; brch_instr_detectd_IF = 0; predict_br_taken = 0;
    brch_instr_detectd_ID = 0; brch_hazard_stall = 0; actual_brch_result = 0;
    brch_target_ID = 32'd0;
  endtask

  task automatic test_reset();
    clear_inputs();
    #1 rst = 1'b1;
    #2;
    n_checks++; if (pc_if !== RESET_PC) begin n_err++; $display("FAIL reset_pc_if: got %h want %h", pc_if, RESET_PC); end
    n_checks++; if (pc_id !== 32'd0) begin n_err++; $display("FAIL reset_pc_id: got %h want 0", pc_id); end
    n_checks++; if (pred_taken_id !== 1'b0) begin n_err++; $display("FAIL reset_pred: got %b want 0", pred_taken_id); end
    n_checks++; if (flush_if_id !== 1'b0) begin n_err++; $display("FAIL reset_flush: got %b want 0", flush_if_id); end
    n_checks++; if (brch_resolved_cnt !== 16'd0 || brch_mispred_cnt !== 16'd0) begin
      n_err++; $display("FAIL reset_cnt: got %0d/%0d want 0/0", brch_resolved_cnt, brch_mispred_cnt);
    end
    tick();
    rst = 1'b0;
  endtask

  task automatic test_sequential(input int n);
    for (int i = 0; i < n; i++) begin
      exp_pc_q.push_back(pc_if + 32'd4); exp_nm_q.push_back("seq_pc");
      tick();
      e_pc = exp_pc_q.pop_front(); e_nm = exp_nm_q.pop_front();
      n_checks++; if (pc_if !== e_pc) begin n_err++; $display("FAIL %s: got %h want %h", e_nm, pc_if, e_pc); end
      n_checks++; if (flush_if_id !== 1'b0) begin n_err++; $display("FAIL seq_flush: got %b want 0", flush_if_id); end
    end
  endtask

  task automatic test_cold_btb();
    brch_instr_detectd_IF = 1; predict_br_taken = 1;
    exp_pc_q.push_back(32'h24); exp_nm_q.push_back("cold_fallthrough");
    tick(); clear_inputs();
    e_pc = exp_pc_q.pop_front(); e_nm = exp_nm_q.pop_front();
    n_checks++; if (pc_if !== e_pc) begin n_err++; $display("FAIL %s: got %h want %h", e_nm, pc_if, e_pc); end
    n_checks++; if (pc_id !== 32'h20 || pred_taken_id !== 1'b0) begin
      n_err++; $display("FAIL cold_record: got %h/%b want 00000020/0", pc_id, pred_taken_id);
    end
    brch_instr_detectd_ID = 1; actual_brch_result = 1; brch_target_ID = 32'h100;
    #1;
    n_checks++; if (flush_if_id !== 1'b1) begin n_err++; $display("FAIL cold_flush: got %b want 1", flush_if_id); end
    exp_pc_q.push_back(32'h100); exp_nm_q.push_back("cold_redirect");
    tick(); clear_inputs(); #1;
    e_pc = exp_pc_q.pop_front(); e_nm = exp_nm_q.pop_front();
    n_checks++; if (pc_if !== e_pc) begin n_err++; $display("FAIL %s: got %h want %h", e_nm, pc_if, e_pc); end
    n_checks++; if (pc_id !== 32'd0 || flush_if_id !== 1'b0) begin
      n_err++; $display("FAIL cold_bubble: got pc_id=%h flush=%b want 0/0", pc_id, flush_if_id);
    end
    n_checks++; if (brch_resolved_cnt !== 16'd1 || brch_mispred_cnt !== 16'd1) begin
      n_err++; $display("FAIL cold_cnt: got %0d/%0d want 1/1", brch_resolved_cnt, brch_mispred_cnt);
    end
  endtask

  task automatic test_btb_hit();
    exp_pc_q.push_back(32'h104); exp_nm_q.push_back("hit_step");
    tick();
    e_pc = exp_pc_q.pop_front(); e_nm = exp_nm_q.pop_front();
    n_checks++; if (pc_if !== e_pc) begin n_err++; $display("FAIL %s: got %h want %h", e_nm, pc_if, e_pc); end
    // Branch at 0x100 mispredicted taken to 0x20: seeds BTB[0] and returns fetch to 0x20.
    brch_instr_detectd_ID = 1; actual_brch_result = 1; brch_target_ID = 32'h20;
    exp_pc_q.push_back(32'h20); exp_nm_q.push_back("hit_back_to_20");
    tick(); clear_inputs();
    e_pc = exp_pc_q.pop_front(); e_nm = exp_nm_q.pop_front();
    n_checks++; if (pc_if !== e_pc) begin n_err++; $display("FAIL %s: got %h want %h", e_nm, pc_if, e_pc); end
    brch_instr_detectd_IF = 1; predict_br_taken = 1;
    exp_pc_q.push_back(32'h100); exp_nm_q.push_back("hit_btb_target");
    tick(); clear_inputs();
    e_pc = exp_pc_q.pop_front(); e_nm = exp_nm_q.pop_front();
    n_checks++; if (pc_if !== e_pc) begin n_err++; $display("FAIL %s: got %h want %h", e_nm, pc_if, e_pc); end
    n_checks++; if (pc_id !== 32'h20 || pred_taken_id !== 1'b1) begin
      n_err++; $display("FAIL hit_record: got %h/%b want 00000020/1", pc_id, pred_taken_id);
    end
    // Correct taken resolution in ID while IF at 0x100 hits BTB[0] back to 0x20.
    brch_instr_detectd_ID = 1; actual_brch_result = 1; brch_target_ID = 32'h100;
    brch_instr_detectd_IF = 1; predict_br_taken = 1;
    #1;
    n_checks++; if (flush_if_id !== 1'b0) begin n_err++; $display("FAIL hit_no_flush: got %b want 0", flush_if_id); end
    exp_pc_q.push_back(32'h20); exp_nm_q.push_back("hit_loop");
    tick(); clear_inputs();
    e_pc = exp_pc_q.pop_front(); e_nm = exp_nm_q.pop_front();
    n_checks++; if (pc_if !== e_pc) begin n_err++; $display("FAIL %s: got %h want %h", e_nm, pc_if, e_pc); end
    n_checks++; if (brch_resolved_cnt !== 16'd3 || brch_mispred_cnt !== 16'd2) begin
      n_err++; $display("FAIL hit_cnt: got %0d/%0d want 3/2", brch_resolved_cnt, brch_mispred_cnt);
    end
  endtask

  task automatic test_not_taken();
    brch_instr_detectd_ID = 1; actual_brch_result = 1; brch_target_ID = 32'h20;
    brch_instr_detectd_IF = 1; predict_br_taken = 1;
    exp_pc_q.push_back(32'h100); exp_nm_q.push_back("nt_predicted");
    tick(); clear_inputs();
    e_pc = exp_pc_q.pop_front(); e_nm = exp_nm_q.pop_front();
    n_checks++; if (pc_if !== e_pc) begin n_err++; $display("FAIL %s: got %h want %h", e_nm, pc_if, e_pc); end
    brch_instr_detectd_ID = 1; actual_brch_result = 0;
    #1;
    n_checks++; if (flush_if_id !== 1'b1) begin n_err++; $display("FAIL nt_flush: got %b want 1", flush_if_id); end
    exp_pc_q.push_back(32'h24); exp_nm_q.push_back("nt_redirect");
    tick(); clear_inputs();
    e_pc = exp_pc_q.pop_front(); e_nm = exp_nm_q.pop_front();
    n_checks++; if (pc_if !== e_pc) begin n_err++; $display("FAIL %s: got %h want %h", e_nm, pc_if, e_pc); end
    n_checks++; if (brch_resolved_cnt !== 16'd5 || brch_mispred_cnt !== 16'd3) begin
      n_err++; $display("FAIL nt_cnt: got %0d/%0d want 5/3", brch_resolved_cnt, brch_mispred_cnt);
    end
    tick();
    brch_instr_detectd_ID = 1; actual_brch_result = 1; brch_target_ID = 32'h20;
    tick(); clear_inputs();
    // BTB[8] must still hold 0x20 -> 0x100 after the not-taken resolution.
    brch_instr_detectd_IF = 1; predict_br_taken = 1;
    exp_pc_q.push_back(32'h100); exp_nm_q.push_back("nt_btb_unchanged");
    tick(); clear_inputs();
    e_pc = exp_pc_q.pop_front(); e_nm = exp_nm_q.pop_front();
    n_checks++; if (pc_if !== e_pc) begin n_err++; $display("FAIL %s: got %h want %h", e_nm, pc_if, e_pc); end
  endtask

  task automatic test_hazard();
    brch_instr_detectd_ID = 1; actual_brch_result = 0; brch_hazard_stall = 1; stall_if = 1;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_checks++; if (flush_if_id !== 1'b0) begin n_err++; $display("FAIL hz_flush_%0d: got %b want 0", i, flush_if_id); end
      exp_pc_q.push_back(32'h100); exp_nm_q.push_back("hz_hold");
      tick();
      e_pc = exp_pc_q.pop_front(); e_nm = exp_nm_q.pop_front();
      n_checks++; if (pc_if !== e_pc || brch_resolved_cnt !== 16'd6 || brch_mispred_cnt !== 16'd4) begin
        n_err++; $display("FAIL %s: got pc=%h cnt=%0d/%0d want %h 6/4", e_nm, pc_if, brch_resolved_cnt, brch_mispred_cnt, e_pc);
      end
    end
    brch_hazard_stall = 0;
    #1;
    n_checks++; if (flush_if_id !== 1'b1) begin n_err++; $display("FAIL hz_release_flush: got %b want 1", flush_if_id); end
    exp_pc_q.push_back(32'h24); exp_nm_q.push_back("hz_redirect_over_stall");
    tick(); clear_inputs();
    e_pc = exp_pc_q.pop_front(); e_nm = exp_nm_q.pop_front();
    n_checks++; if (pc_if !== e_pc) begin n_err++; $display("FAIL %s: got %h want %h", e_nm, pc_if, e_pc); end
    n_checks++; if (pc_id !== 32'd0 || brch_resolved_cnt !== 16'd7 || brch_mispred_cnt !== 16'd5) begin
      n_err++; $display("FAIL hz_after: got pc_id=%h cnt=%0d/%0d want 0 7/5", pc_id, brch_resolved_cnt, brch_mispred_cnt);
    end
  endtask

  task automatic test_saturation_and_reset();
    int exp_res;
    int exp_mis;
    exp_res = 7; exp_mis = 5;
    // Bubble record carries pred 0, so a held taken resolution mispredicts every cycle.
    brch_instr_detectd_ID = 1; actual_brch_result = 1; brch_target_ID = 32'h40;
    for (int i = 0; i < 65540; i++) begin
      tick();
      if (exp_res < 16'hFFFF) exp_res++;
      if (exp_mis < 16'hFFFF) exp_mis++;
    end
    n_checks++; if (brch_mispred_cnt !== exp_mis[15:0]) begin n_err++; $display("FAIL sat_mispred: got %h want %h", brch_mispred_cnt, exp_mis[15:0]); end
    n_checks++; if (brch_resolved_cnt !== exp_res[15:0]) begin n_err++; $display("FAIL sat_resolved: got %h want %h", brch_resolved_cnt, exp_res[15:0]); end
    #2 rst = 1'b1;
    #1;
    n_checks++; if (pc_if !== RESET_PC || flush_if_id !== 1'b0) begin
      n_err++; $display("FAIL midrst: got pc=%h flush=%b want %h 0", pc_if, flush_if_id, RESET_PC);
    end
    n_checks++; if (brch_mispred_cnt !== 16'd0) begin n_err++; $display("FAIL midrst_cnt: got %h want 0", brch_mispred_cnt); end
    clear_inputs();
    tick();
    rst = 1'b0;
    n_checks++; if (pc_if !== RESET_PC) begin n_err++; $display("FAIL midrst_hold: got %h want %h", pc_if, RESET_PC); end
    test_sequential(8);
    brch_instr_detectd_IF = 1; predict_br_taken = 1;
    exp_pc_q.push_back(32'h24); exp_nm_q.push_back("rst_btb_miss");
    tick(); clear_inputs();
    e_pc = exp_pc_q.pop_front(); e_nm = exp_nm_q.pop_front();
    n_checks++; if (pc_if !== e_pc || pred_taken_id !== 1'b0) begin
      n_err++; $display("FAIL %s: got %h/%b want %h/0", e_nm, pc_if, pred_taken_id, e_pc);
    end
  endtask

  initial begin
    test_reset();
    test_sequential(4);
    n_checks++; if (brch_resolved_cnt !== 16'd0 || brch_mispred_cnt !== 16'd0) begin
      n_err++; $display("FAIL seq_cnt: got %0d/%0d want 0/0", brch_resolved_cnt, brch_mispred_cnt);
    end
    test_sequential(4);
    test_cold_btb();
    test_btb_hit();
    test_not_taken();
    test_hazard();
    test_saturation_and_reset();
    n_checks++; if (exp_pc_q.size() != 0) begin n_err++; $display("FAIL scoreboard_leftover: got %0d want 0", exp_pc_q.size()); end
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/brnch_pc_redirect_ctrl.md
Name: brnch_pc_redirect_ctrl

Overview:
- IF-stage next-PC and redirect controller directly upstream of the correlational GHP branch predictor.
- Owns the PC register, a direct-mapped branch target buffer (BTB), and the IF/ID prediction record.
- Consumes the predictor's taken prediction in IF and the branch outcome in ID. On a mismatch it flushes IF/ID and redirects fetch.
- Drives the same `brch_instr_detectd_ID` / `brch_hazard_stall` qualification the predictor uses, so both update on the identical cycle.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- BTB_IDX_W, 4, log2 of BTB entries (16 entries). Index = `pc[BTB_IDX_W+1:2]`.
- CNT_W, 16, width of the performance counters.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous reset, active-high.
- stall_if  in  1  hold PC and the IF/ID record (load-use or structural stall).
- brch_instr_detectd_IF  in  1  predecode: the instruction at `pc_if` is a branch.
- predict_br_taken  in  1  predictor output for the current IF branch.
- brch_instr_detectd_ID  in  1  a branch is in ID.
- brch_hazard_stall  in  1  branch operands not ready; resolution is deferred.
- actual_brch_result  in  1  resolved direction in ID (1 = taken).
- brch_target_ID  in  32  resolved taken target from ID.
- pc_if  out  32  current fetch address.
- pc_id  out  32  PC of the instruction in ID.
- pred_taken_id  out  1  effective prediction carried with the ID instruction.
- flush_if_id  out  1  kill the IF/ID instruction this cycle (combinational).
- brch_resolved_cnt  out  CNT_W  resolved branches, saturating.
- brch_mispred_cnt  out  CNT_W  mispredictions, saturating.

Behaviour:
- Reset (async, `rst`=1): state and outputs take these values.
  - `pc_if` = RESET_PC.
  - `pc_id` = 0, `pred_taken_id` = 0.
  - All BTB valid bits = 0.
  - Both counters = 0.
  - `flush_if_id` = 0.
  - Reset asserted mid-redirect discards the redirect.
- BTB lookup (combinational on `pc_if`):
  - Entry = {valid, tag = `pc[31:BTB_IDX_W+2]`, target[31:0]}.
  - `btb_hit` = valid & tag match.
- Effective prediction: `eff_pred` = `brch_instr_detectd_IF` & `predict_br_taken` & `btb_hit`. A taken prediction with a BTB miss falls through, i.e. is treated as not-taken.
- Resolution: `resolve` = `brch_instr_detectd_ID` & !`brch_hazard_stall`.
- Misprediction: `mispred` = `resolve` & (`actual_brch_result` != `pred_taken_id`).
- `flush_if_id` = `mispred`, same cycle, combinational.
- Next PC, in priority order, registered at the next edge:
  1. `mispred` & `actual_brch_result` → `brch_target_ID`.
  2. `mispred` & !`actual_brch_result` → `pc_id` + 4.
  3. `stall_if` → hold.
  4. `eff_pred` → BTB target.
  5. Otherwise → `pc_if` + 4.
  - Redirect overrides `stall_if`.
  - Adds are 32-bit modulo; 32'hFFFF_FFFC + 4 wraps to 0.
- IF/ID record:
  - If `mispred`: `pc_id` and `pred_taken_id` are cleared to 0 (bubble).
  - Else if `stall_if`: hold.
  - Else: `pc_id` <= `pc_if`, `pred_taken_id` <= `eff_pred`.
- BTB write:
  - On `resolve` & `actual_brch_result`, write entry[`pc_id` index] = {1, `pc_id` tag, `brch_target_ID`}.
  - This overwrites any existing entry (no replacement policy).
  - A not-taken resolution does not modify the BTB.
  - A read of the same index in the write cycle returns the old contents; the new value is visible the next cycle.
- While `brch_hazard_stall` = 1: no resolve, no BTB write, no counter update. Resolution occurs on the first cycle the stall drops.
- Counters:
  - `brch_resolved_cnt` += 1 on `resolve`.
  - `brch_mispred_cnt` += 1 on `mispred`.
  - Both saturate at all-ones and never wrap.
- Latency:
  - Redirect: mispredict is detected in cycle N; `pc_if` = corrected PC in cycle N+1. Penalty is exactly 1 fetch bubble.

Test Plan:
1. Reset, then 4 cycles with no stall → `pc_if` = 0, 4, 8, 12, 16; `flush_if_id` = 0 throughout; counters = 0.
2. Branch at 0x20 (predict=1, BTB cold) → falls through to 0x24, `pred_taken_id` = 0. In ID, actual=1, target=0x100 → `flush_if_id` = 1 that cycle; next `pc_if` = 0x100; BTB[8] written; both counters = 1.
3. Revisit 0x20 with predict=1 → `pc_if` next = 0x100 via BTB hit. Resolve taken → no flush; resolved = 2, mispred = 1.
4. Revisit 0x20, predict=1, actual=0 → flush; next `pc_if` = 0x24; BTB[8] unchanged.
5. `brch_hazard_stall` = 1 for 3 cycles with a mispredicted branch in ID → no flush or counter change; on the cycle the stall drops, `flush_if_id` = 1 and the redirect is taken. A simultaneous `stall_if` = 1 is ignored.
6. Force `brch_mispred_cnt` to 0xFFFF via repeated mispredicts → it stays at 0xFFFF. Assert `rst` mid-cycle → `pc_if` = RESET_PC immediately and BTB misses on the next lookup.
